// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type, requester owner encoding and the
// line-offset width helper used by the mem_arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int unsigned LINE_BITS_DEF = 128;
    localparam int unsigned ADDR_W_DEF    = 32;

    // Number of byte-offset bits inside one cache line.
    function automatic int unsigned offset_width(input int unsigned line_bits);
        return $clog2(line_bits / 8);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side bus of the I/D memory arbiter.
// Modport master is the arbiter's view (serves both caches, drives the
// memory command); modport slave is the surrounding caches + memory.
interface mem_arbiter_if #(
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned ADDR_W    = 32
);
    logic                 i_req_valid;
    logic [ADDR_W-1:0]    i_req_addr;
    logic                 i_req_ready;
    logic                 i_resp_valid;
    logic [LINE_BITS-1:0] i_resp_data;

    logic                 d_req_valid;
    logic                 d_req_write;
    logic [ADDR_W-1:0]    d_req_addr;
    logic [LINE_BITS-1:0] d_req_wdata;
    logic                 d_req_ready;
    logic                 d_resp_valid;
    logic [LINE_BITS-1:0] d_resp_data;

    logic                 mem_req_valid;
    logic                 mem_req_write;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [LINE_BITS-1:0] mem_req_wdata;
    logic                 mem_req_ready;
    logic                 mem_resp_valid;
    logic [LINE_BITS-1:0] mem_resp_data;

    modport master (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick between the I and D requesters.
// The grant is combinational; the last-grant pointer updates on accept and
// resets to I so that D wins the first tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    owner_t last_q, last_d;

    // Lone requester wins; on a tie the side not granted last time wins.
    always_comb begin
        gnt = '0;
        if (req[OWN_I] && req[OWN_D]) begin
            if (last_q == OWN_I) gnt[OWN_D] = 1'b1;
            else                 gnt[OWN_I] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // Remember who was granted when a transfer actually happens.
    always_comb begin
        last_d = last_q;
        if (accept) last_d = gnt[OWN_D] ? OWN_D : OWN_I;
    end

    // Last-grant pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= OWN_I;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-cache and the
// D-cache. One transaction outstanding, round-robin on ties, responses routed
// back to the owner as a one-cycle pulse.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LINE_BITS = LINE_BITS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic [31:0]   i_grant_num,
    output logic [31:0]   d_grant_num,
    output logic [31:0]   wait_cycles
);

    localparam int unsigned       OFF_W     = offset_width(LINE_BITS);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;

    state_t               state_q, state_d;
    owner_t               own_q, own_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 i_rv_q, i_rv_d, d_rv_q, d_rv_d;
    logic [LINE_BITS-1:0] i_rd_q, i_rd_d, d_rd_q, d_rd_d;

    logic [1:0] req, gnt;
    logic       idle, i_ready, d_ready, i_fire, d_fire, accept;

    assign req = {bus.d_req_valid, bus.i_req_valid};

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    // Readies are masked by reset so nothing is offered while held in reset.
    assign idle    = (state_q == IDLE) && reset;
    assign i_ready = idle && gnt[OWN_I];
    assign d_ready = idle && gnt[OWN_D];
    assign i_fire  = i_ready && bus.i_req_valid;
    assign d_fire  = d_ready && bus.d_req_valid;
    assign accept  = i_fire || d_fire;

    assign bus.i_req_ready   = i_ready;
    assign bus.d_req_ready   = d_ready;
    assign bus.mem_req_valid = (state_q == ISSUE);
    assign bus.mem_req_write = wr_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.i_resp_valid  = i_rv_q;
    assign bus.i_resp_data   = i_rd_q;
    assign bus.d_resp_valid  = d_rv_q;
    assign bus.d_resp_data   = d_rd_q;

    // Next-state, command latch and response routing.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        i_rv_d  = 1'b0;
        d_rv_d  = 1'b0;
        i_rd_d  = i_rd_q;
        d_rd_d  = d_rd_q;
        unique case (state_q)
            IDLE: begin
                if (d_fire) begin
                    own_d   = OWN_D;
                    wr_d    = bus.d_req_write;
                    addr_d  = bus.d_req_addr & ADDR_MASK;
                    wdata_d = bus.d_req_wdata;
                    state_d = ISSUE;
                end else if (i_fire) begin
                    own_d   = OWN_I;
                    wr_d    = 1'b0;
                    addr_d  = bus.i_req_addr & ADDR_MASK;
                    wdata_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (own_q == OWN_I) begin
                        i_rv_d = 1'b1;
                        i_rd_d = bus.mem_resp_data;
                    end else begin
                        d_rv_d = 1'b1;
                        d_rd_d = wr_q ? '0 : bus.mem_resp_data;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched command and registered responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            own_q   <= OWN_I;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_rv_q  <= 1'b0;
            d_rv_q  <= 1'b0;
            i_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            i_rv_q  <= i_rv_d;
            d_rv_q  <= d_rv_d;
            i_rd_q  <= i_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] i_grant_q, i_grant_d, d_grant_q, d_grant_d, wait_q, wait_d;
    logic        stall;

    assign stall = (bus.i_req_valid && !i_ready) || (bus.d_req_valid && !d_ready);

    // Saturating grant and contention counters.
    always_comb begin
        i_grant_d = i_grant_q;
        d_grant_d = d_grant_q;
        wait_d    = wait_q;
        if (i_fire && (i_grant_q != '1)) i_grant_d = i_grant_q + 32'd1;
        if (d_fire && (d_grant_q != '1)) d_grant_d = d_grant_q + 32'd1;
        if (stall  && (wait_q    != '1)) wait_d    = wait_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_grant_q <= '0;
            d_grant_q <= '0;
            wait_q    <= '0;
        end else begin
            i_grant_q <= i_grant_d;
            d_grant_q <= d_grant_d;
            wait_q    <= wait_d;
        end
    end

    assign i_grant_num = i_grant_q;
    assign d_grant_num = d_grant_q;
    assign wait_cycles = wait_q;
`else
    assign i_grant_num = '0;
    assign d_grant_num = '0;
    assign wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference model kept in the bench.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LB         = 128;
    localparam int unsigned AW         = 32;
    localparam int unsigned LINE_BYTES = LB / 8;
    typedef logic [LB-1:0] w_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_grant_num, d_grant_num, wait_cycles;

    mem_arbiter_if #(.LINE_BITS(LB), .ADDR_W(AW)) bus ();

    mem_arbiter #(.LINE_BITS(LB), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .i_grant_num (i_grant_num),
        .d_grant_num (d_grant_num),
        .wait_cycles (wait_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one outstanding transaction, owner alternation on ties.
    bit        m_busy, m_issue, m_last_d, m_own_d, m_wr, m_rv_i, m_rv_d;
    logic [AW-1:0] m_addr;
    w_t        m_wdata, m_rdata;
    longint    m_gi, m_gd, m_wc;

    // Observations of the DUT.
    bit        fired_i, fired_d;
    bit        q_grants[$];
    int        pulses_i, pulses_d, t_fire_i, t_pulse_i;
    logic [AW-1:0] cap_addr;
    w_t        cap_wdata, cap_i_data, cap_d_data;

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic w_t rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_issue = 0; m_last_d = 0; m_rv_i = 0; m_rv_d = 0;
        m_gi = 0; m_gd = 0; m_wc = 0;
    endtask

    task automatic drive_idle();
        bus.i_req_valid = 0; bus.i_req_addr = '0;
        bus.d_req_valid = 0; bus.d_req_write = 0; bus.d_req_addr = '0; bus.d_req_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
    endtask

    // One clock: check outputs for the current inputs, advance the model
    // across the coming rising edge, return just after the next falling edge.
    task automatic step();
        bit ei, ed, was_busy;
        #1;
        if (!reset) model_reset();
        ei = 0; ed = 0;
        if (reset && !m_busy) begin
            if (bus.i_req_valid && bus.d_req_valid) begin
                ed = !m_last_d;
                ei = m_last_d;
            end else begin
                ei = bus.i_req_valid;
                ed = bus.d_req_valid;
            end
        end
        chk("i_req_ready", w_t'(bus.i_req_ready), w_t'(ei));
        chk("d_req_ready", w_t'(bus.d_req_ready), w_t'(ed));
        chk("mem_req_valid", w_t'(bus.mem_req_valid), w_t'(m_issue));
        if (m_issue) begin
            chk("mem_req_addr", w_t'(bus.mem_req_addr), w_t'(m_addr));
            chk("mem_req_write", w_t'(bus.mem_req_write), w_t'(m_wr));
            if (m_wr) chk("mem_req_wdata", bus.mem_req_wdata, m_wdata);
        end
        chk("i_resp_valid", w_t'(bus.i_resp_valid), w_t'(m_rv_i));
        chk("d_resp_valid", w_t'(bus.d_resp_valid), w_t'(m_rv_d));
        if (m_rv_i) chk("i_resp_data", bus.i_resp_data, m_rdata);
        if (m_rv_d) chk("d_resp_data", bus.d_resp_data, m_rdata);
        if (!reset) begin
            chk("rst_i_resp_data", bus.i_resp_data, '0);
            chk("rst_d_resp_data", bus.d_resp_data, '0);
            chk("rst_mem_req_addr", w_t'(bus.mem_req_addr), '0);
            chk("rst_mem_req_write", w_t'(bus.mem_req_write), '0);
            chk("rst_mem_req_wdata", bus.mem_req_wdata, '0);
        end
`ifdef MEM_ARB_STATS_EN
        chk("i_grant_num", w_t'(i_grant_num), w_t'(sat32(m_gi)));
        chk("d_grant_num", w_t'(d_grant_num), w_t'(sat32(m_gd)));
        chk("wait_cycles", w_t'(wait_cycles), w_t'(sat32(m_wc)));
`else
        chk("i_grant_num", w_t'(i_grant_num), '0);
        chk("d_grant_num", w_t'(d_grant_num), '0);
        chk("wait_cycles", w_t'(wait_cycles), '0);
`endif
        fired_i = bus.i_req_valid && bus.i_req_ready;
        fired_d = bus.d_req_valid && bus.d_req_ready;
        if (fired_i) begin q_grants.push_back(1'b0); t_fire_i = cyc; end
        if (fired_d) q_grants.push_back(1'b1);
        if (bus.i_resp_valid) begin pulses_i++; t_pulse_i = cyc; cap_i_data = bus.i_resp_data; end
        if (bus.d_resp_valid) begin pulses_d++; cap_d_data = bus.d_resp_data; end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
            cap_addr  = bus.mem_req_addr;
            cap_wdata = bus.mem_req_wdata;
        end
        if (reset) begin
            was_busy = m_busy;
            if ((bus.i_req_valid && !ei) || (bus.d_req_valid && !ed)) m_wc++;
            m_rv_i = 0; m_rv_d = 0;
            if (m_busy && !m_issue && bus.mem_resp_valid) begin
                m_busy = 0;
                if (m_own_d) begin m_rv_d = 1; m_rdata = m_wr ? '0 : bus.mem_resp_data; end
                else begin m_rv_i = 1; m_rdata = bus.mem_resp_data; end
            end else if (m_issue && bus.mem_req_ready) begin
                m_issue = 0;
            end
            if (!was_busy && (ei || ed)) begin
                m_busy = 1; m_issue = 1; m_own_d = ed; m_last_d = ed;
                if (ed) begin
                    m_wr = bus.d_req_write; m_addr = align(bus.d_req_addr);
                    m_wdata = bus.d_req_wdata; m_gd++;
                end else begin
                    m_wr = 0; m_addr = align(bus.i_req_addr); m_wdata = '0; m_gi++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // Let any outstanding transaction finish with a willing memory.
    task automatic drain();
        bit expired;
        bus.i_req_valid = 0; bus.d_req_valid = 0;
        bus.mem_req_ready = 1; bus.mem_resp_valid = 1;
        for (int n = 0; n < 20 && (m_busy || m_rv_i || m_rv_d); n++) step();
        expired = m_busy || m_rv_i || m_rv_d;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0;
        step();
        chk("drain_bound", w_t'(expired), '0);
    endtask

    initial begin
        drive_idle();
        model_reset();
        @(negedge clk);
        step(); step();
        reset = 1;

        // I-only read, memory ready at once, response two cycles after handshake.
        pulses_i = 0; pulses_d = 0;
        bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_1234; bus.mem_req_ready = 1;
        step();
        chk("t1_fire", w_t'(fired_i), w_t'(1));
        bus.i_req_valid = 0;
        step();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_data = {16{8'hA5}};
        step();
        bus.mem_resp_valid = 0; bus.mem_resp_data = '0;
        step(); step(); step();
        chk("t1_mem_addr", w_t'(cap_addr), w_t'(32'h0000_1230));
        chk("t1_i_pulses", w_t'(pulses_i), w_t'(1));
        chk("t1_d_pulses", w_t'(pulses_d), w_t'(0));
        chk("t1_latency", w_t'(t_pulse_i - t_fire_i), w_t'(3));
        chk("t1_i_data", cap_i_data, {16{8'hA5}});
`ifdef MEM_ARB_STATS_EN
        chk("t1_i_grant", w_t'(i_grant_num), w_t'(1));
`endif

        // Both valid right after reset: D first, I next.
        reset = 0; step(); reset = 1;
        q_grants.delete();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_2000;
        bus.d_req_valid = 1; bus.d_req_write = 0; bus.d_req_addr = 32'h0000_3047;
        bus.mem_req_ready = 1; bus.mem_resp_valid = 1; bus.mem_resp_data = rnd_line();
        for (int n = 0; n < 40 && q_grants.size() < 2; n++) begin
            step();
            if (fired_i) bus.i_req_valid = 0;
            if (fired_d) bus.d_req_valid = 0;
        end
        chk("t2_grants", w_t'(q_grants.size()), w_t'(2));
        if (q_grants.size() >= 2) begin
            chk("t2_first_is_d", w_t'(q_grants[0]), w_t'(1));
            chk("t2_second_is_i", w_t'(q_grants[1]), w_t'(0));
        end
`ifdef MEM_ARB_STATS_EN
        chk("t2_wait_cycles", w_t'(wait_cycles), w_t'(3));
`endif
        drain();

        // D writeback held off by memory for four cycles.
        pulses_i = 0; pulses_d = 0;
        bus.d_req_valid = 1; bus.d_req_write = 1; bus.d_req_addr = 32'h0000_4ABC;
        bus.d_req_wdata = {4{32'hDEAD_BEEF}};
        step();
        chk("t3_fire", w_t'(fired_d), w_t'(1));
        bus.d_req_valid = 0; bus.d_req_write = 0; bus.d_req_wdata = '0; bus.d_req_addr = '0;
        repeat (4) step();
        bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready = 0;
        step();
        bus.mem_resp_valid = 1; bus.mem_resp_data = {4{32'h1357_9BDF}};
        step();
        bus.mem_resp_valid = 0;
        step(); step();
        chk("t3_mem_addr", w_t'(cap_addr), w_t'(32'h0000_4AB0));
        chk("t3_mem_wdata", cap_wdata, {4{32'hDEAD_BEEF}});
        chk("t3_d_pulses", w_t'(pulses_d), w_t'(1));
        chk("t3_i_pulses", w_t'(pulses_i), w_t'(0));
        chk("t3_d_data", cap_d_data, '0);

        // Stray memory response while idle.
        pulses_i = 0; pulses_d = 0;
        bus.mem_resp_valid = 1; bus.mem_resp_data = rnd_line();
        repeat (3) step();
        bus.mem_resp_valid = 0;
        chk("t4_i_pulses", w_t'(pulses_i), w_t'(0));
        chk("t4_d_pulses", w_t'(pulses_d), w_t'(0));

        // Reset while waiting for memory, then a clean I read.
        bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_5558; bus.mem_req_ready = 1;
        step();
        bus.i_req_valid = 0;
        step();
        bus.mem_req_ready = 0;
        step();
        pulses_i = 0; pulses_d = 0;
        reset = 0; bus.d_req_valid = 1; bus.mem_resp_valid = 1; bus.mem_resp_data = rnd_line();
        step();
        bus.d_req_valid = 0; bus.mem_resp_valid = 0;
        step();
        reset = 1;
        step();
        bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_666F; bus.mem_req_ready = 1;
        step();
        chk("t5_fire", w_t'(fired_i), w_t'(1));
        bus.i_req_valid = 0;
        step();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_data = {8{16'h0F1E}};
        step();
        bus.mem_resp_valid = 0;
        step(); step();
        chk("t5_mem_addr", w_t'(cap_addr), w_t'(32'h0000_6660));
        chk("t5_i_pulses", w_t'(pulses_i), w_t'(1));
        chk("t5_d_pulses", w_t'(pulses_d), w_t'(0));
        chk("t5_i_data", cap_i_data, {8{16'h0F1E}});

        // Both requesters always valid: grants alternate starting with D.
        q_grants.delete();
        bus.i_req_valid = 1; bus.i_req_addr = $urandom();
        bus.d_req_valid = 1; bus.d_req_addr = $urandom(); bus.d_req_write = 1'($urandom_range(0, 1));
        bus.d_req_wdata = rnd_line();
        for (int n = 0; n < 300 && q_grants.size() < 6; n++) begin
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_resp_data  = rnd_line();
            step();
            if (fired_i) bus.i_req_addr = $urandom();
            if (fired_d) begin
                bus.d_req_addr = $urandom(); bus.d_req_write = 1'($urandom_range(0, 1));
                bus.d_req_wdata = rnd_line();
            end
        end
        chk("t6_grants", w_t'(q_grants.size()), w_t'(6));
        for (int k = 0; k < 6; k++)
            if (k < q_grants.size())
                chk($sformatf("t6_grant%0d", k), w_t'(q_grants[k]), w_t'((k % 2) == 0));
        drain();

        // Randomized traffic with a random memory and stray responses.
        for (int n = 0; n < 400; n++) begin
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_resp_data  = rnd_line();
            step();
            if (fired_i || !bus.i_req_valid) begin
                bus.i_req_valid = ($urandom_range(0, 2) == 0);
                bus.i_req_addr  = $urandom();
            end
            if (fired_d || !bus.d_req_valid) begin
                bus.d_req_valid = ($urandom_range(0, 2) == 0);
                bus.d_req_write = 1'($urandom_range(0, 1));
                bus.d_req_addr  = $urandom();
                bus.d_req_wdata = rnd_line();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single line-granularity data-memory port between the instruction cache and the data cache. It sits between both caches' miss/writeback interfaces and the memory inside `cpu`. It serialises misses with round-robin fairness, keeps one transaction outstanding at a time, and routes each memory response back to its owner. Optional counters report grant and contention activity alongside the existing cache hit/miss statistics.

## Interface
- `LINE_BITS`, default 128: cache line width in bits.
- `ADDR_W`, default 32: byte address width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: I-cache read request.
- `i_req_addr` in ADDR_W: I-cache address.
- `i_req_ready` out 1: I-side request accepted this cycle.
- `i_resp_valid` out 1: one-cycle pulse carrying the I-side line.
- `i_resp_data` out LINE_BITS: returned line.
- `d_req_valid` in 1: D-cache request.
- `d_req_write` in 1: 1 = line writeback, 0 = line fill.
- `d_req_addr` in ADDR_W: D-cache address.
- `d_req_wdata` in LINE_BITS: writeback data.
- `d_req_ready` out 1: D-side request accepted this cycle.
- `d_resp_valid` out 1: one-cycle pulse on read data or write acknowledge.
- `d_resp_data` out LINE_BITS: read line; zero for writes.
- `mem_req_valid`, `mem_req_write`, `mem_req_addr`, `mem_req_wdata` out 1/1/ADDR_W/LINE_BITS: memory command.
- `mem_req_ready` in 1: memory accepts the command.
- `mem_resp_valid` in 1: memory completion, for both reads and writes.
- `mem_resp_data` in LINE_BITS: memory read line.
- `i_grant_num`, `d_grant_num`, `wait_cycles` out 32 each: statistics (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- IDLE:
  - A transfer occurs when a requester's valid and ready are both high.
  - Ready is combinational: high only for the requester chosen by the arbiter while in IDLE.
  - The accepted command is latched (owner, write, line-aligned address, wdata). The FSM then goes to ISSUE.
- Arbitration:
  - With a single valid requester, that requester is chosen.
  - With both valid, the requester not granted last time is chosen.
  - The last-grant pointer resets to I, so the D side wins the first tie.
- ISSUE:
  - `mem_req_valid`=1 with the latched command.
  - On `mem_req_ready`=1 the FSM goes to WAIT.
- WAIT:
  - On `mem_resp_valid`=1, the response is registered to the owner and the FSM returns to IDLE.
  - The owner's resp_valid pulses high for exactly one cycle.
  - The non-owner's resp_valid stays 0.
- Address alignment: `mem_req_addr` = request address with the low log2(LINE_BITS/8) bits forced to 0.
- `mem_resp_valid` in IDLE or ISSUE is ignored: no response is produced and no state changes.
- Requesters must hold valid and payload stable until ready. The arbiter does not check this.
- Reset values:
  - All outputs 0: ready, resp_valid, resp_data, mem_req_*, counters.
  - Latched command cleared.
- Reset mid-transaction: the in-flight transaction is dropped and the FSM returns to IDLE. The memory is reset in the same reset domain.

## Timing
- Cycle 0: handshake in IDLE.
- Cycle 1: `mem_req_valid` high. Commands are registered, never combinational from requesters.
- Cycle k: `mem_resp_valid` arrives in WAIT.
- Cycle k+1: owner's resp_valid is high, the FSM is in IDLE, and a new request may be accepted in that same cycle.
- Minimum request-to-response latency: 3 cycles (memory ready at cycle 1, response at cycle 2).
- Back-to-back: while one requester is in ISSUE/WAIT, the other's ready stays 0 until IDLE.

## Configuration
- Macro `MEM_ARB_STATS_EN`.
- Defined:
  - `i_grant_num` / `d_grant_num` increment on each accepted I/D request.
  - `wait_cycles` increments on every cycle in which at least one req_valid is high without its ready.
  - All three counters saturate at 32'hFFFF_FFFF.
- Undefined: the three ports still exist, are tied to 0, and no counter flops are built.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT);
  - the owner encoding (OWN_I=0, OWN_D=1);
  - the offset-width constant derived from LINE_BITS.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from two valids plus the last-grant pointer, with a registered pointer update on grant.

## Test plan
- I-only read of 0x0000_1234, memory ready immediately, response 2 cycles later with 128'hA5… → `mem_req_addr`=0x0000_1230, `i_resp_valid` pulses once with A5…, D side silent; `i_grant_num`=1 if stats enabled.
- Both valid in the first cycle after reset → D granted first, I granted at the first IDLE after D's response; with stats, `wait_cycles` ≥ duration of D's transaction.
- D writeback, `d_req_wdata`=128'hDEAD…, memory holds `mem_req_ready` low 4 cycles → `mem_req_*` stable all 4 cycles, `d_resp_valid` pulse with `d_resp_data`=0.
- Stray `mem_resp_valid` while in IDLE → no resp_valid on either side, state stays IDLE.
- `reset` asserted low during WAIT → all outputs 0 immediately; after release, a new I request completes normally.
- Both requesters continuously valid for 6 transactions → grants alternate D,I,D,I,D,I.
